// File: rtl/data_mem_interface_pkg.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Package : data_mem_interface_pkg                                         |
// | Purpose : Shared access-size codes and load-extension helper for the     |
// |           data memory load/store bus master.                             |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

package data_mem_interface_pkg;

   // Store size select codes (also used internally as the generic access size)
   localparam logic [1:0] STORE_SB = 2'b00;
   localparam logic [1:0] STORE_SH = 2'b01;
   localparam logic [1:0] STORE_SW = 2'b10;

   // Load select codes: bit 2 marks the zero-extending variants
   localparam logic [2:0] LOAD_LB  = 3'b000;
   localparam logic [2:0] LOAD_LH  = 3'b001;
   localparam logic [2:0] LOAD_LW  = 3'b010;
   localparam logic [2:0] LOAD_LBU = 3'b100;
   localparam logic [2:0] LOAD_LHU = 3'b101;

   // Map a load select onto the access size shared with stores, so one lane
   // aligner serves both directions.
   function automatic logic [1:0] load_size(input logic [2:0] sel);
      case (sel)
         LOAD_LB, LOAD_LBU: return STORE_SB;
         LOAD_LH, LOAD_LHU: return STORE_SH;
         default:           return STORE_SW;
      endcase
   endfunction

   // Sign/zero extension of a read word that has already been shifted so the
   // addressed byte sits in bits [7:0].
   function automatic logic [31:0] extend_load(input logic [2:0] sel,
                                               input logic [31:0] w);
      case (sel)
         LOAD_LB:  return {{24{w[7]}},  w[7:0]};
         LOAD_LH:  return {{16{w[15]}}, w[15:0]};
         LOAD_LBU: return {24'h000000,  w[7:0]};
         LOAD_LHU: return {16'h0000,    w[15:0]};
         default:  return w;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_interface_lane_aligner.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module  : data_mem_interface_lane_aligner                                |
// | Purpose : Combinational byte-lane steering. From the access size and the |
// |           low address bits produce byte enables, lane-shifted write data |
// |           and the misalignment flag.                                     |
// | Ports   : i_size        access size (STORE_SB/SH/SW encoding)            |
// |           i_addr_lo     byte offset within the word                      |
// |           i_wdata       low-aligned store data                           |
// |           o_sel         byte enables                                     |
// |           o_wdata       store data shifted onto its byte lanes           |
// |           o_misaligned  access crosses its natural boundary              |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module data_mem_interface_lane_aligner
   import data_mem_interface_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   output logic [3:0]  o_sel,
   output logic [31:0] o_wdata,
   output logic        o_misaligned
);

   always_comb begin
      o_sel        = 4'b1111;
      o_misaligned = 1'b0;
      case (i_size)
         STORE_SB: begin
            o_sel = 4'b0001 << i_addr_lo;
         end
         STORE_SH: begin
            o_sel        = 4'b0011 << {i_addr_lo[1], 1'b0};
            o_misaligned = i_addr_lo[0];
         end
         // Word, and the unused code, are treated as full-word accesses
         default: begin
            o_sel        = 4'b1111;
            o_misaligned = |i_addr_lo;
         end
      endcase
   end

   assign o_wdata = i_wdata << {i_addr_lo, 3'b000};

endmodule

`default_nettype wire

// File: rtl/data_mem_interface.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module  : data_mem_interface                                             |
// | Purpose : Load/store bus master between the CPU execute stage and data   |
// |           memory. Runs one single-beat req/ack bus transaction per CPU   |
// |           access, stalls the pipeline until it completes and returns    |
// |           extended load data. Misaligned accesses complete without a    |
// |           bus cycle; an unanswered cycle ends in a bus error.            |
// | Params  : TIMEOUT       BUS cycles without ack before bus error (1..255) |
// | Ports   : I_clk/I_rst_n clock, async active-low reset                    |
// |           I_req/I_we/I_storesel/I_loadsel/I_addr/I_wdata  CPU request    |
// |           O_stall/O_done/O_rdata/O_misaligned/O_buserr    CPU response   |
// |           O_bus_cyc/O_bus_we/O_bus_addr/O_bus_sel/O_bus_wdata  bus out   |
// |           I_bus_ack/I_bus_rdata                                bus in    |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module data_mem_interface
   import data_mem_interface_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        I_clk,
   input  logic        I_rst_n,
   input  logic        I_req,
   input  logic        I_we,
   input  logic [1:0]  I_storesel,
   input  logic [2:0]  I_loadsel,
   input  logic [31:0] I_addr,
   input  logic [31:0] I_wdata,
   output logic        O_stall,
   output logic        O_done,
   output logic [31:0] O_rdata,
   output logic        O_misaligned,
   output logic        O_buserr,
   output logic        O_bus_cyc,
   output logic        O_bus_we,
   output logic [31:0] O_bus_addr,
   output logic [3:0]  O_bus_sel,
   output logic [31:0] O_bus_wdata,
   input  logic        I_bus_ack,
   input  logic [31:0] I_bus_rdata
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUS  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_BUS  = ST_BUS,
      S_DONE = ST_DONE
   } state_e;

   localparam logic [7:0] C_TIMEOUT = TIMEOUT[7:0];

   state_e      state_q,    state_d;
   logic [7:0]  cnt_q,      cnt_d;
   logic [29:0] addr_q,     addr_d;
   logic        we_q,       we_d;
   logic [3:0]  sel_q,      sel_d;
   logic [31:0] wdata_q,    wdata_d;
   logic [2:0]  loadsel_q,  loadsel_d;
   logic [1:0]  off_q,      off_d;
   logic [31:0] rdata_q,    rdata_d;
   logic        misal_q,    misal_d;
   logic        buserr_q,   buserr_d;

   logic [1:0]  w_size;
   logic [3:0]  w_sel;
   logic [31:0] w_wdata;
   logic        w_misal;
   logic [7:0]  w_cnt_inc;
   logic [31:0] w_word;
   logic        w_cyc;
   logic        w_done;

   assign w_size = I_we ? I_storesel : load_size(I_loadsel);

   data_mem_interface_lane_aligner u_lane_aligner (
      .i_size       (w_size),
      .i_addr_lo    (I_addr[1:0]),
      .i_wdata      (I_wdata),
      .o_sel        (w_sel),
      .o_wdata      (w_wdata),
      .o_misaligned (w_misal)
   );

   // Saturating so a very long stall can never wrap back below TIMEOUT
   assign w_cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

   // Read word moved down so the addressed byte/half lands at bit 0
   assign w_word = I_bus_rdata >> {off_q, 3'b000};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      we_d      = we_q;
      sel_d     = sel_q;
      wdata_d   = wdata_q;
      loadsel_d = loadsel_q;
      off_d     = off_q;
      rdata_d   = rdata_q;
      misal_d   = misal_q;
      buserr_d  = buserr_q;
      case (state_q)
         S_IDLE: begin
            if (I_req) begin
               addr_d    = I_addr[31:2];
               we_d      = I_we;
               sel_d     = w_sel;
               wdata_d   = w_wdata;
               loadsel_d = I_loadsel;
               off_d     = I_addr[1:0];
               cnt_d     = 8'd0;
               rdata_d   = 32'h0;
               buserr_d  = 1'b0;
               misal_d   = w_misal;
               state_d   = w_misal ? S_DONE : S_BUS;
            end
         end
         S_BUS: begin
            cnt_d = w_cnt_inc;
            // Ack wins over an expiring timeout in the same cycle
            if (I_bus_ack) begin
               state_d = S_DONE;
               rdata_d = we_q ? 32'h0 : extend_load(loadsel_q, w_word);
            end else if (w_cnt_inc == C_TIMEOUT) begin
               state_d  = S_DONE;
               buserr_d = 1'b1;
               rdata_d  = 32'h0;
            end
         end
         S_DONE: begin
            // Response flags live for exactly the DONE cycle
            state_d  = S_IDLE;
            rdata_d  = 32'h0;
            misal_d  = 1'b0;
            buserr_d = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 8'd0;
         addr_q    <= 30'd0;
         we_q      <= 1'b0;
         sel_q     <= 4'd0;
         wdata_q   <= 32'h0;
         loadsel_q <= 3'd0;
         off_q     <= 2'd0;
         rdata_q   <= 32'h0;
         misal_q   <= 1'b0;
         buserr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         wdata_q   <= wdata_d;
         loadsel_q <= loadsel_d;
         off_q     <= off_d;
         rdata_q   <= rdata_d;
         misal_q   <= misal_d;
         buserr_q  <= buserr_d;
      end
   end

   assign w_cyc  = (state_q == S_BUS);
   assign w_done = (state_q == S_DONE);

   // Bus lines are qualified by the cycle so they read 0 whenever idle
   assign O_bus_cyc    = w_cyc;
   assign O_bus_we     = w_cyc & we_q;
   assign O_bus_addr   = w_cyc ? {addr_q, 2'b00} : 32'h0;
   assign O_bus_sel    = w_cyc ? sel_q : 4'd0;
   assign O_bus_wdata  = w_cyc ? wdata_q : 32'h0;

   assign O_done       = w_done;
   assign O_rdata      = rdata_q;
   assign O_misaligned = w_done & misal_q;
   assign O_buserr     = w_done & buserr_q;
   assign O_stall      = I_req & ~w_done;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_interface.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module  : tb_data_mem_interface                                          |
// | Purpose : Self-checking bench for data_mem_interface. Response data is   |
// |           scoreboarded; bus-side lines and latencies are checked inline. |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_interface;
   import data_mem_interface_pkg::*;

   localparam int unsigned TIMEOUT = 4;

   logic        I_clk = 1'b0;
   logic        I_rst_n = 1'b0;
   logic        I_req = 1'b0;
   logic        I_we = 1'b0;
   logic [1:0]  I_storesel = 2'b00;
   logic [2:0]  I_loadsel = 3'b000;
   logic [31:0] I_addr = 32'h0;
   logic [31:0] I_wdata = 32'h0;
   logic        I_bus_ack = 1'b0;
   logic [31:0] I_bus_rdata = 32'h0;
   logic        O_stall, O_done, O_misaligned, O_buserr;
   logic        O_bus_cyc, O_bus_we;
   logic [31:0] O_rdata, O_bus_addr, O_bus_wdata;
   logic [3:0]  O_bus_sel;

   data_mem_interface #(.TIMEOUT(TIMEOUT)) u_dut (
      .I_clk        (I_clk),
      .I_rst_n      (I_rst_n),
      .I_req        (I_req),
      .I_we         (I_we),
      .I_storesel   (I_storesel),
      .I_loadsel    (I_loadsel),
      .I_addr       (I_addr),
      .I_wdata      (I_wdata),
      .O_stall      (O_stall),
      .O_done       (O_done),
      .O_rdata      (O_rdata),
      .O_misaligned (O_misaligned),
      .O_buserr     (O_buserr),
      .O_bus_cyc    (O_bus_cyc),
      .O_bus_we     (O_bus_we),
      .O_bus_addr   (O_bus_addr),
      .O_bus_sel    (O_bus_sel),
      .O_bus_wdata  (O_bus_wdata),
      .I_bus_ack    (I_bus_ack),
      .I_bus_rdata  (I_bus_rdata)
   );

   always #5 I_clk = ~I_clk;

   typedef struct packed {
      logic [31:0] rdata;
      logic        mis;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Response monitor: every completion pulse consumes one expectation
   always @(negedge I_clk) begin
      if (I_rst_n && O_done) begin
         check("sb_expected_done", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check("sb_rdata",      O_rdata,            mon_e.rdata);
            check("sb_misaligned", 32'(O_misaligned),  32'(mon_e.mis));
            check("sb_buserr",     32'(O_buserr),      32'(mon_e.err));
         end
      end
   end

   // One CPU access. Request is raised mid-cycle 0; cycle k is the k-th
   // negedge afterwards. ack_cyc<0 means the slave never answers.
   task automatic access(input string name, input logic we, input logic [1:0] ss,
                         input logic [2:0] ls, input logic [31:0] addr, input logic [31:0] wd,
                         input int ack_cyc, input logic [31:0] bus_rd, input bit drop_req,
                         input logic [3:0] exp_sel, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rd, input logic exp_mis, input logic exp_err,
                         input int exp_done, input int exp_cyc);
      int k;
      int cyc_n;
      bit done_seen;
      bit bus_checked;
      exp_t e;
      e.rdata = exp_rd;
      e.mis   = exp_mis;
      e.err   = exp_err;
      sb_q.push_back(e);
      I_req = 1'b1; I_we = we; I_storesel = ss; I_loadsel = ls; I_addr = addr; I_wdata = wd;
      k = 0; cyc_n = 0; done_seen = 1'b0; bus_checked = 1'b0;
      while (!done_seen && k < 20) begin
         @(negedge I_clk);
         k++;
         I_bus_ack = 1'b0;
         if (O_done) begin
            done_seen = 1'b1;
            check({name, "_done_cycle"}, 32'(k), 32'(exp_done));
            if (I_req) check({name, "_stall_at_done"}, 32'(O_stall), 32'd0);
            I_req = 1'b0;
         end else begin
            if (I_req) check({name, "_stall"}, 32'(O_stall), 32'd1);
            if (O_bus_cyc) begin
               cyc_n++;
               if (!bus_checked) begin
                  bus_checked = 1'b1;
                  check({name, "_bus_addr"}, O_bus_addr, {addr[31:2], 2'b00});
                  check({name, "_bus_sel"},  32'(O_bus_sel), 32'(exp_sel));
                  check({name, "_bus_we"},   32'(O_bus_we), 32'(we));
                  if (we) check({name, "_bus_wdata"}, O_bus_wdata, exp_wd);
               end
               if (k == ack_cyc) begin
                  I_bus_ack   = 1'b1;
                  I_bus_rdata = bus_rd;
               end
            end
            if (drop_req && k == 2) I_req = 1'b0;
         end
      end
      if (!done_seen) check({name, "_done_seen"}, 32'(O_done), 32'd1);
      check({name, "_cyc_cycles"}, 32'(cyc_n), 32'(exp_cyc));
      I_bus_ack = 1'b0;
      I_req     = 1'b0;
      @(negedge I_clk);
      check({name, "_idle_gap"}, {30'd0, O_bus_cyc, O_done}, 32'd0);
   endtask

   initial begin
      #1;
      check("rst_bus_cyc",   32'(O_bus_cyc), 32'd0);
      check("rst_done",      32'(O_done), 32'd0);
      check("rst_rdata",     O_rdata, 32'h0);
      check("rst_bus_addr",  O_bus_addr, 32'h0);
      check("rst_bus_sel",   32'(O_bus_sel), 32'd0);
      check("rst_bus_wdata", O_bus_wdata, 32'h0);
      check("rst_flags",     {28'd0, O_misaligned, O_buserr, O_bus_we, O_stall}, 32'd0);
      @(negedge I_clk);
      @(negedge I_clk);
      I_rst_n = 1'b1;
      @(negedge I_clk);

      //     name   we    store     load      addr          wdata        ack rdata         drop sel      exp_wd        exp_rd        mis  err  done cyc
      access("sb",  1'b1, STORE_SB, LOAD_LB,  32'h0000_1003, 32'h0000_00A5, 1, 32'h0,        0, 4'b1000, 32'hA500_0000, 32'h0,        1'b0, 1'b0, 2, 1);
      access("lh",  1'b0, STORE_SB, LOAD_LH,  32'h0000_2002, 32'h0,         1, 32'h80FF_1234, 0, 4'b1100, 32'h0,         32'hFFFF_80FF, 1'b0, 1'b0, 2, 1);
      access("lhu", 1'b0, STORE_SB, LOAD_LHU, 32'h0000_2002, 32'h0,         1, 32'h80FF_1234, 0, 4'b1100, 32'h0,         32'h0000_80FF, 1'b0, 1'b0, 2, 1);
      access("swm", 1'b1, STORE_SW, LOAD_LB,  32'h0000_3001, 32'h1234_5678, 1, 32'h0,        0, 4'b0000, 32'h0,         32'h0,        1'b1, 1'b0, 1, 0);
      access("lto", 1'b0, STORE_SB, LOAD_LW,  32'h0000_4000, 32'h0,        -1, 32'h0,        0, 4'b1111, 32'h0,         32'h0,        1'b0, 1'b1, 5, 4);
      access("ldr", 1'b0, STORE_SB, LOAD_LW,  32'h0000_5004, 32'h0,         3, 32'h1234_5678, 1, 4'b1111, 32'h0,         32'h1234_5678, 1'b0, 1'b0, 4, 3);
      access("lb",  1'b0, STORE_SB, LOAD_LB,  32'h0000_6001, 32'h0,         2, 32'h0000_8000, 0, 4'b0010, 32'h0,         32'hFFFF_FF80, 1'b0, 1'b0, 3, 2);
      access("lbu", 1'b0, STORE_SB, LOAD_LBU, 32'h0000_6003, 32'h0,         1, 32'h7F00_0000, 0, 4'b1000, 32'h0,         32'h0000_007F, 1'b0, 1'b0, 2, 1);
      access("lwe", 1'b0, STORE_SB, LOAD_LW,  32'h0000_7000, 32'h0,         4, 32'hCAFE_F00D, 0, 4'b1111, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b0, 5, 4);
      access("lhm", 1'b0, STORE_SB, LOAD_LH,  32'h0000_2001, 32'h0,         1, 32'h0,        0, 4'b0000, 32'h0,         32'h0,        1'b1, 1'b0, 1, 0);
      access("sh",  1'b1, STORE_SH, LOAD_LB,  32'h0000_8002, 32'h0000_BEEF, 1, 32'h0,        0, 4'b1100, 32'hBEEF_0000, 32'h0,        1'b0, 1'b0, 2, 1);

      // Reset in the middle of a bus cycle: no completion may follow
      I_req = 1'b1; I_we = 1'b0; I_loadsel = LOAD_LW; I_addr = 32'h0000_9000;
      @(negedge I_clk);
      check("rst_mid_pre_cyc", 32'(O_bus_cyc), 32'd1);
      #2;
      I_rst_n = 1'b0;
      I_req   = 1'b0;
      #1;
      check("rst_mid_cyc",   32'(O_bus_cyc), 32'd0);
      check("rst_mid_addr",  O_bus_addr, 32'h0);
      check("rst_mid_sel",   32'(O_bus_sel), 32'd0);
      check("rst_mid_flags", {29'd0, O_done, O_stall, O_bus_we}, 32'd0);
      @(negedge I_clk);
      I_rst_n = 1'b1;
      @(negedge I_clk);
      @(negedge I_clk);
      check("rst_rel_idle", {30'd0, O_bus_cyc, O_done}, 32'd0);

      access("sw",  1'b1, STORE_SW, LOAD_LB,  32'h0000_A000, 32'h1122_3344, 2, 32'h0,        0, 4'b1111, 32'h1122_3344, 32'h0,        1'b0, 1'b0, 3, 2);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
